pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Control-flow sequencer for the program counter block. It accepts one decoded control-flow operation per cycle (sequential, absolute jump, relative jump, conditional branch, call, return) and drives the PC block's enable, mux select and load address. It keeps a small return-address stack and inserts a one-cycle flush bubble after every taken redirect. It sits between the instruction decoder and the PC block (`en_pc`, `selMp`, `PC_Iaddr`), with `PC_Oaddr` fed back as `pc_cur`.

## Interface
- `RST_VEC`, 8'h00, address loaded into the PC in the BOOT cycle.
- `STK_DEPTH`, 4, number of return-stack entries; legal range 1..7.
- `clk_pc` in 1: single clock; all state updates on the rising edge.
- `rst_pc` in 1: synchronous, active-low reset.
- `stall` in 1: freezes the sequencer and the PC while high (RUN state only).
- `op_valid` in 1: `op`/`target`/`br_cond` are valid this cycle.
- `op` in 3: 000 NEXT, 001 JMP, 010 RJMP, 011 BR, 100 CALL, 101 RET; 110/111 are treated as NEXT.
- `target` in 8: absolute address (JMP/CALL) or signed offset (RJMP/BR).
- `br_cond` in 1: branch condition for BR; 1 means taken.
- `pc_cur` in 8: current PC value, from the PC block output.
- `en_pc` out 1: PC load enable.
- `selMp` out 1: PC mux select; 0 = incremented PC, 1 = `PC_Iaddr`.
- `PC_Iaddr` out 8: redirect address.
- `op_ready` out 1: op accepted on this edge when `op_valid` is also 1.
- `flush` out 1: the instruction fetched this cycle must be discarded.
- `stk_depth` out 3: number of occupied stack entries.
- `stk_err` out 1: sticky stack overflow/underflow flag.

## Operation
- FSM states: BOOT, RUN, FLUSH. The state register is updated on `clk_pc`.
- Outputs are combinational from the state and the current inputs.
- **BOOT:** `en_pc`=1, `selMp`=1, `PC_Iaddr`=`RST_VEC`, `op_ready`=0, then go to RUN.
- **RUN, `stall`=1:** `en_pc`=0, `op_ready`=0, state held. The op is not accepted and the decoder must hold it.
- **RUN, `stall`=0:** `op_ready`=1.
  - `op_valid`=0, or op is NEXT/110/111: `en_pc`=1, `selMp`=0.
  - **JMP:** redirect to `target`.
  - **RJMP:** redirect to `pc_cur + 1 + sext(target)`, modulo 256 (wraps both ways).
  - **BR**, `br_cond`=1: same as RJMP. `br_cond`=0: same as NEXT, no flush.
  - **CALL:** push `pc_cur + 1` (mod 256), then redirect to `target`.
  - **RET:** pop the top entry and redirect to it.
- **Redirect:** `en_pc`=1, `selMp`=1, `PC_Iaddr`=computed address, next state FLUSH.
- **FLUSH:** lasts exactly one cycle regardless of `stall`. `en_pc`=0, `flush`=1, `op_ready`=0, then go to RUN.
- **Stack:** LIFO with `STK_DEPTH` entries; `stk_depth` always equals the occupied count.
  - CALL with the stack full: no push, contents unchanged, jump still taken, `stk_err` set.
  - RET with the stack empty: `stk_err` set, treated as NEXT (no redirect, no flush).
- `stk_err` stays set until reset.

## Timing
- A redirect accepted at edge k: the PC holds the new address after edge k; `flush`=1 during cycle k+1; the next op can be accepted at edge k+2.
- Sequential ops sustain one per cycle with zero bubbles.
- **Reset:** an edge with `rst_pc`=0 sets state to BOOT, empties the stack, and sets `stk_depth`=0 and `stk_err`=0.
- While `rst_pc`=0, outputs are forced to `en_pc`=0, `selMp`=0, `PC_Iaddr`=0, `flush`=0, `op_ready`=0.
- Reset asserted mid-FLUSH or mid-stall aborts the operation; nothing is pushed or popped on that edge.
- The first cycle after reset release is BOOT, so the PC equals `RST_VEC` after that edge.
- `pc_cur` is sampled combinationally in the acceptance cycle; no other input registering.

## Configuration
- `PCSEQ_STACK_EN` defined: return stack, CALL push and RET pop are implemented as above.
- `PCSEQ_STACK_EN` undefined:
  - No stack storage; `stk_depth` is tied to 0.
  - CALL behaves exactly as JMP (flush included, `stk_err` unaffected).
  - RET behaves as NEXT and sets `stk_err`.

## Test plan
- **Reset/boot:** hold `rst_pc`=0 for 2 cycles, release, `RST_VEC`=8'h10 -> all outputs 0 during reset; BOOT cycle shows `en_pc`=1, `selMp`=1, `PC_Iaddr`=8'h10; PC=8'h10 afterwards; `op_ready`=1 next cycle.
- **Sequential plus stall:** 4 NEXT with `stall` high in the 3rd cycle -> PC increments 10,11,12 (hold),13; `op_ready`=0 only in the stall cycle.
- **Relative wrap:** `pc_cur`=8'hFE, RJMP `target`=8'h03 -> `PC_Iaddr`=8'h02, `flush`=1 next cycle. `pc_cur`=8'h01, BR `target`=8'hFC, `br_cond`=1 -> 8'hFE. Same BR with `br_cond`=0 -> PC=8'h02, no flush.
- **Call/return nesting:** CALL 8'h40 at `pc_cur` 8'h20, then CALL 8'h60 at 8'h41 -> `stk_depth` 2; RET returns to 8'h42, RET returns to 8'h21; `stk_depth` 0 and `stk_err`=0.
- **Overflow/underflow:** 5 CALLs with `STK_DEPTH`=4 -> 5th jumps but `stk_depth` stays 4 and `stk_err`=1. After reset, a RET -> PC+1, no flush, `stk_err`=1.
- **Reset mid-FLUSH:** assert `rst_pc`=0 in the FLUSH cycle after a CALL -> `stk_depth`=0 and state BOOT after the edge.

Source files
------------

// File: rtl/pc_sequencer.sv
// Control-flow sequencer driving the PC block: BOOT/RUN/FLUSH FSM plus return-address stack.
// Optional feature macro: PCSEQ_STACK_EN (return stack for CALL/RET; without it CALL acts as JMP).
module pc_sequencer #(
   parameter logic [7:0] RST_VEC   = 8'h00,
   parameter int         STK_DEPTH = 4
) (
   input  logic       clk_pc,
   input  logic       rst_pc,
   input  logic       stall,
   input  logic       op_valid,
   input  logic [2:0] op,
   input  logic [7:0] target,
   input  logic       br_cond,
   input  logic [7:0] pc_cur,
   output logic       en_pc,
   output logic       selMp,
   output logic [7:0] PC_Iaddr,
   output logic       op_ready,
   output logic       flush,
   output logic [2:0] stk_depth,
   output logic       stk_err
);

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_FLUSH} state_t;

   localparam logic [2:0] OP_JMP  = 3'b001;
   localparam logic [2:0] OP_RJMP = 3'b010;
   localparam logic [2:0] OP_BR   = 3'b011;
   localparam logic [2:0] OP_CALL = 3'b100;
   localparam logic [2:0] OP_RET  = 3'b101;

   state_t     state, state_nx;
   logic       err_q, err_set, redirect;
   logic [7:0] raddr, pc_inc, pc_rel;

   // Unsigned add of the offset equals sign-extended add modulo 256.
   assign pc_inc  = pc_cur + 8'd1;
   assign pc_rel  = pc_inc + target;
   assign stk_err = err_q;

`ifdef PCSEQ_STACK_EN
   logic [7:0] stk [STK_DEPTH];
   logic [2:0] sp;
   logic [7:0] top;
   logic       push, pop, full, empty;

   assign full      = (sp == 3'(STK_DEPTH));
   assign empty     = (sp == 3'd0);
   assign stk_depth = sp;

   always_comb begin
      top = '0;
      for (int i = 0; i < STK_DEPTH; i++)
         if (sp == 3'(i + 1)) top = stk[i];
   end

   always_ff @(posedge clk_pc) begin
      if (!rst_pc) begin
         sp <= '0;
      end else if (push) begin
         for (int i = 0; i < STK_DEPTH; i++)
            if (sp == 3'(i)) stk[i] <= pc_inc;
         sp <= sp + 3'd1;
      end else if (pop) begin
         sp <= sp - 3'd1;
      end
   end
`else
   assign stk_depth = 3'd0;
`endif

   always_ff @(posedge clk_pc) begin
      if (!rst_pc) begin
         state <= S_BOOT;
         err_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (err_set) err_q <= 1'b1;
      end
   end

   always_comb begin
      en_pc    = 1'b0;
      selMp    = 1'b0;
      PC_Iaddr = '0;
      op_ready = 1'b0;
      flush    = 1'b0;
      state_nx = state;
      err_set  = 1'b0;
      redirect = 1'b0;
      raddr    = '0;
`ifdef PCSEQ_STACK_EN
      push     = 1'b0;
      pop      = 1'b0;
`endif
      if (rst_pc) begin
         case (state)
            S_BOOT: begin
               en_pc    = 1'b1;
               selMp    = 1'b1;
               PC_Iaddr = RST_VEC;
               state_nx = S_RUN;
            end
            S_FLUSH: begin
               flush    = 1'b1;
               state_nx = S_RUN;
            end
            S_RUN: begin
               if (!stall) begin
                  op_ready = 1'b1;
                  en_pc    = 1'b1;
                  if (op_valid) begin
                     case (op)
                        OP_JMP:  begin redirect = 1'b1; raddr = target; end
                        OP_RJMP: begin redirect = 1'b1; raddr = pc_rel; end
                        OP_BR:   begin redirect = br_cond; raddr = pc_rel; end
                        OP_CALL: begin
                           redirect = 1'b1;
                           raddr    = target;
`ifdef PCSEQ_STACK_EN
                           if (full) err_set = 1'b1;
                           else      push    = 1'b1;
`endif
                        end
                        OP_RET: begin
`ifdef PCSEQ_STACK_EN
                           // Underflow degrades to a sequential step.
                           if (empty) begin
                              err_set = 1'b1;
                           end else begin
                              pop      = 1'b1;
                              redirect = 1'b1;
                              raddr    = top;
                           end
`else
                           err_set = 1'b1;
`endif
                        end
                        default: ;
                     endcase
                  end
                  if (redirect) begin
                     selMp    = 1'b1;
                     PC_Iaddr = raddr;
                     state_nx = S_FLUSH;
                  end
               end
            end
            default: state_nx = S_BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: models the PC register and scoreboards expected outputs per cycle.
module tb_pc_sequencer;

   localparam logic [2:0] NXT = 3'b000, JMP = 3'b001, RJMP = 3'b010;
   localparam logic [2:0] BR  = 3'b011, CALL = 3'b100, RET = 3'b101;

   logic       clk_pc = 1'b0;
   logic       rst_pc = 1'b0;
   logic       stall = 1'b0, op_valid = 1'b0, br_cond = 1'b0;
   logic [2:0] op = 3'b000;
   logic [7:0] target = 8'h00;
   logic [7:0] pc = 8'h00;
   logic       en_pc, selMp, op_ready, flush, stk_err;
   logic [7:0] PC_Iaddr;
   logic [2:0] stk_depth;

   typedef struct {
      string       tag;
      logic        chk_addr;
      logic [15:0] v;
   } exp_t;

   exp_t sb[$];
   int   npass = 0;
   int   ntot  = 0;

   always #5 clk_pc = ~clk_pc;

   pc_sequencer #(.RST_VEC(8'h10), .STK_DEPTH(4)) dut (
      .clk_pc(clk_pc), .rst_pc(rst_pc), .stall(stall), .op_valid(op_valid),
      .op(op), .target(target), .br_cond(br_cond), .pc_cur(pc),
      .en_pc(en_pc), .selMp(selMp), .PC_Iaddr(PC_Iaddr), .op_ready(op_ready),
      .flush(flush), .stk_depth(stk_depth), .stk_err(stk_err)
   );

   // PC block model
   always @(posedge clk_pc)
      if (en_pc) pc <= selMp ? PC_Iaddr : pc + 8'd1;

   function automatic logic [15:0] pack(input logic en, sel, input logic [7:0] addr,
                                        input logic rdy, fl, input logic [2:0] dep, input logic err);
      return {en, sel, addr, rdy, fl, dep, err};
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      ntot++;
      assert (obs === expv) npass++;
      else $error("FAIL %s: got %h, want %h", tag, obs, expv);
   endtask

   task automatic chk_pc(input string tag, input logic [7:0] expv);
      chk(tag, {8'h00, pc}, {8'h00, expv});
   endtask

   // One cycle: drive inputs, queue expectation, compare at negedge, advance past posedge.
   task automatic cyc(input string tag, input logic st, vl, input logic [2:0] o,
                      input logic [7:0] tg, input logic bc,
                      input logic e_en, e_sel, input logic [7:0] e_addr,
                      input logic e_rdy, e_fl, input logic [2:0] e_dep, input logic e_err);
      exp_t e, got;
      stall = st; op_valid = vl; op = o; target = tg; br_cond = bc;
      e.tag      = tag;
      e.chk_addr = e_sel | ~rst_pc;
      e.v        = pack(e_en, e_sel, e.chk_addr ? e_addr : 8'h00, e_rdy, e_fl, e_dep, e_err);
      sb.push_back(e);
      @(negedge clk_pc);
      got = sb.pop_front();
      chk(got.tag, pack(en_pc, selMp, got.chk_addr ? PC_Iaddr : 8'h00, op_ready, flush,
                        stk_depth, stk_err), got.v);
      @(posedge clk_pc);
      #1;
   endtask

   task automatic nxt(input string tag, input logic [2:0] dep, input logic err);
      cyc(tag, 1'b0, 1'b1, NXT, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, dep, err);
   endtask

   // Flush cycle driven with stall high: it must still last exactly one cycle.
   task automatic flc(input string tag, input logic [2:0] dep, input logic err);
      cyc(tag, 1'b1, 1'b1, JMP, 8'hCC, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, dep, err);
   endtask

   task automatic red(input string tag, input logic [2:0] o, input logic [7:0] tg, input logic bc,
                      input logic [7:0] addr, input logic [2:0] dep, input logic err);
      cyc(tag, 1'b0, 1'b1, o, tg, bc, 1'b1, 1'b1, addr, 1'b1, 1'b0, dep, err);
   endtask

   initial begin
      rst_pc = 1'b0;
      @(posedge clk_pc);
      #1;
      cyc("rst_hold", 1'b0, 1'b1, JMP, 8'h55, 1'b0, 0, 0, 8'h00, 0, 0, 3'd0, 1'b0);
      rst_pc = 1'b1;
      cyc("boot", 1'b0, 1'b1, JMP, 8'h77, 1'b0, 1, 1, 8'h10, 0, 0, 3'd0, 1'b0);
      chk_pc("pc_boot", 8'h10);

      nxt("seq1", 3'd0, 1'b0);   chk_pc("pc_seq1", 8'h11);
      nxt("seq2", 3'd0, 1'b0);   chk_pc("pc_seq2", 8'h12);
      cyc("stall", 1'b1, 1'b1, NXT, 8'h00, 1'b0, 0, 0, 8'h00, 0, 0, 3'd0, 1'b0);
      chk_pc("pc_stall", 8'h12);
      nxt("seq4", 3'd0, 1'b0);   chk_pc("pc_seq4", 8'h13);
      cyc("no_valid", 1'b0, 1'b0, JMP, 8'hAA, 1'b0, 1, 0, 8'h00, 1, 0, 3'd0, 1'b0);
      cyc("op110", 1'b0, 1'b1, 3'b110, 8'hAA, 1'b0, 1, 0, 8'h00, 1, 0, 3'd0, 1'b0);
      chk_pc("pc_op110", 8'h15);

      red("jmp_fe", JMP, 8'hFE, 1'b0, 8'hFE, 3'd0, 1'b0);  flc("fl_jmp", 3'd0, 1'b0);
      chk_pc("pc_fe", 8'hFE);
      red("rjmp_wrap", RJMP, 8'h03, 1'b0, 8'h02, 3'd0, 1'b0);  flc("fl_rjmp", 3'd0, 1'b0);
      chk_pc("pc_rjmp", 8'h02);
      red("jmp_01a", JMP, 8'h01, 1'b0, 8'h01, 3'd0, 1'b0);  flc("fl_01a", 3'd0, 1'b0);
      red("br_taken", BR, 8'hFC, 1'b1, 8'hFE, 3'd0, 1'b0);  flc("fl_br", 3'd0, 1'b0);
      chk_pc("pc_br_taken", 8'hFE);
      red("jmp_01b", JMP, 8'h01, 1'b0, 8'h01, 3'd0, 1'b0);  flc("fl_01b", 3'd0, 1'b0);
      cyc("br_not", 1'b0, 1'b1, BR, 8'hFC, 1'b0, 1, 0, 8'h00, 1, 0, 3'd0, 1'b0);
      chk_pc("pc_br_not", 8'h02);
      nxt("after_br_not", 3'd0, 1'b0);
      chk_pc("pc_after_br_not", 8'h03);

`ifdef PCSEQ_STACK_EN
      red("jmp20", JMP, 8'h20, 1'b0, 8'h20, 3'd0, 1'b0);  flc("fl_20", 3'd0, 1'b0);
      red("call40", CALL, 8'h40, 1'b0, 8'h40, 3'd0, 1'b0);  flc("fl_c40", 3'd1, 1'b0);
      chk_pc("pc_call40", 8'h40);
      nxt("n41", 3'd1, 1'b0);
      red("call60", CALL, 8'h60, 1'b0, 8'h60, 3'd1, 1'b0);  flc("fl_c60", 3'd2, 1'b0);
      red("ret1", RET, 8'h00, 1'b0, 8'h42, 3'd2, 1'b0);  flc("fl_ret1", 3'd1, 1'b0);
      chk_pc("pc_ret1", 8'h42);
      red("ret2", RET, 8'h00, 1'b0, 8'h21, 3'd1, 1'b0);  flc("fl_ret2", 3'd0, 1'b0);
      chk_pc("pc_ret2", 8'h21);

      for (int i = 0; i < 4; i++) begin
         red("ovf_call", CALL, 8'h80 + 8'(i), 1'b0, 8'h80 + 8'(i), 3'(i), 1'b0);
         flc("ovf_fl", 3'(i + 1), 1'b0);
      end
      red("call5", CALL, 8'h90, 1'b0, 8'h90, 3'd4, 1'b0);  flc("fl_call5", 3'd4, 1'b1);
      chk_pc("pc_call5", 8'h90);

      rst_pc = 1'b0;
      cyc("rst2", 1'b0, 1'b0, NXT, 8'h00, 1'b0, 0, 0, 8'h00, 0, 0, 3'd4, 1'b1);
      rst_pc = 1'b1;
      cyc("boot2", 1'b0, 1'b0, NXT, 8'h00, 1'b0, 1, 1, 8'h10, 0, 0, 3'd0, 1'b0);
      cyc("ret_empty", 1'b0, 1'b1, RET, 8'h00, 1'b0, 1, 0, 8'h00, 1, 0, 3'd0, 1'b0);
      chk_pc("pc_ret_empty", 8'h11);
      nxt("after_ret_empty", 3'd0, 1'b1);

      red("call_rf", CALL, 8'h40, 1'b0, 8'h40, 3'd0, 1'b1);
      rst_pc = 1'b0;
      cyc("rst_in_fl", 1'b1, 1'b1, NXT, 8'h00, 1'b0, 0, 0, 8'h00, 0, 0, 3'd1, 1'b1);
      rst_pc = 1'b1;
      cyc("boot3", 1'b0, 1'b0, NXT, 8'h00, 1'b0, 1, 1, 8'h10, 0, 0, 3'd0, 1'b0);
`else
      red("jmp20", JMP, 8'h20, 1'b0, 8'h20, 3'd0, 1'b0);  flc("fl_20", 3'd0, 1'b0);
      red("call40", CALL, 8'h40, 1'b0, 8'h40, 3'd0, 1'b0);  flc("fl_c40", 3'd0, 1'b0);
      chk_pc("pc_call40", 8'h40);
      cyc("ret_nostk", 1'b0, 1'b1, RET, 8'h00, 1'b0, 1, 0, 8'h00, 1, 0, 3'd0, 1'b0);
      chk_pc("pc_ret_nostk", 8'h41);
      nxt("after_ret", 3'd0, 1'b1);
      chk_pc("pc_after_ret", 8'h42);

      rst_pc = 1'b0;
      cyc("rst2", 1'b0, 1'b0, NXT, 8'h00, 1'b0, 0, 0, 8'h00, 0, 0, 3'd0, 1'b1);
      rst_pc = 1'b1;
      cyc("boot2", 1'b0, 1'b0, NXT, 8'h00, 1'b0, 1, 1, 8'h10, 0, 0, 3'd0, 1'b0);
      red("call_rf", CALL, 8'h40, 1'b0, 8'h40, 3'd0, 1'b0);
      rst_pc = 1'b0;
      cyc("rst_in_fl", 1'b1, 1'b1, NXT, 8'h00, 1'b0, 0, 0, 8'h00, 0, 0, 3'd0, 1'b0);
      rst_pc = 1'b1;
      cyc("boot3", 1'b0, 1'b0, NXT, 8'h00, 1'b0, 1, 1, 8'h10, 0, 0, 3'd0, 1'b0);
`endif
      chk_pc("pc_boot3", 8'h10);

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule
